// File: rtl/preset_sequencer_pkg.sv
// Shared types and default widths for the preset sequencer and its tick divider.
package preset_sequencer_pkg;

  localparam int DEFAULT_DIV_W = 2;
  localparam int DEFAULT_CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_ASSERT,
    ST_SETTLE,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/tick_divider.sv
// Programmable clock divider producing a one-cycle slow tick and a registered slow clock.
module tick_divider
  import preset_sequencer_pkg::*;
#(
  parameter int DIV_W = DEFAULT_DIV_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [DIV_W-1:0] div_ratio,
  output logic             slow_tick,
  output logic             slow_clk
);

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] div_ratio_q, div_ratio_d;
  logic             slow_tick_q, slow_tick_d;
  logic             slow_clk_q, slow_clk_d;
  logic             wrap;

  // The ratio is only picked up at wrap so a change never cuts a period short.
  always_comb begin
    wrap        = (div_q == div_ratio_q);
    div_d       = wrap ? '0 : div_q + 1'b1;
    div_ratio_d = wrap ? div_ratio : div_ratio_q;
    slow_tick_d = (div_q == '0);
    slow_clk_d  = (div_q == '0);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      div_q       <= '0;
      div_ratio_q <= div_ratio;
      slow_tick_q <= 1'b0;
      slow_clk_q  <= 1'b0;
    end else begin
      div_q       <= div_d;
      div_ratio_q <= div_ratio_d;
      slow_tick_q <= slow_tick_d;
      slow_clk_q  <= slow_clk_d;
    end
  end

  assign slow_tick = slow_tick_q;
  assign slow_clk  = slow_clk_q;

endmodule

// File: rtl/preset_sequencer.sv
// Sequences a glitch-free preset pulse for slow-domain registers, then a settle wait and an ack.
module preset_sequencer
  import preset_sequencer_pkg::*;
#(
  parameter int DIV_W = DEFAULT_DIV_W,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [DIV_W-1:0] div_ratio,
  input  logic [CNT_W-1:0] preset_len,
  input  logic [CNT_W-1:0] settle_len,
  input  logic             req,
  output logic             slow_tick,
  output logic             slow_clk,
  output logic             preset,
  output logic             busy,
  output logic             ack
);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             preset_q, preset_d;

  tick_divider #(
    .DIV_W(DIV_W)
  ) u_tick_divider (
    .clock     (clock),
    .reset     (reset),
    .div_ratio (div_ratio),
    .slow_tick (slow_tick),
    .slow_clk  (slow_clk)
  );

  // Preset edges only move on slow ticks, keeping a fixed offset to slow_clk.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    preset_d = preset_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          state_d = ST_ALIGN;
          len_d   = (preset_len == '0) ? '0 : preset_len - 1'b1;
        end
      end
      ST_ALIGN: begin
        if (slow_tick) begin
          preset_d = 1'b1;
          cnt_d    = len_q;
          state_d  = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        if (slow_tick) begin
          if (cnt_q == '0) begin
            preset_d = 1'b0;
            cnt_d    = settle_len;
            state_d  = ST_SETTLE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else if (slow_tick) begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d  = ST_IDLE;
        preset_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      len_q    <= '0;
      preset_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      preset_q <= preset_d;
    end
  end

  assign preset = preset_q;
  assign busy   = (state_q != ST_IDLE);
  assign ack    = (state_q == ST_DONE);

endmodule

// File: tb/tb_preset_sequencer.sv
// Directed self-checking bench for preset_sequencer with hand-computed timing expectations.
module tb_preset_sequencer;

  localparam int DIV_W = 2;
  localparam int CNT_W = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic [DIV_W-1:0] div_ratio;
  logic [CNT_W-1:0] preset_len;
  logic [CNT_W-1:0] settle_len;
  logic             req;
  logic             slow_tick;
  logic             slow_clk;
  logic             preset;
  logic             busy;
  logic             ack;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always #5 clock = ~clock;

  preset_sequencer #(
    .DIV_W(DIV_W),
    .CNT_W(CNT_W)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .div_ratio  (div_ratio),
    .preset_len (preset_len),
    .settle_len (settle_len),
    .req        (req),
    .slow_tick  (slow_tick),
    .slow_clk   (slow_clk),
    .preset     (preset),
    .busy       (busy),
    .ack        (ack)
  );

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // Pulses req for one cycle and records event times relative to the req cycle.
  task automatic run_seq(output int t_busy, output int t_rise, output int t_fall,
                         output int t_ack, output int n_ack, output logic tick_before_rise,
                         output logic busy_hole, output logic busy_after);
    int   start;
    logic p_tick;
    logic p_preset;
    t_busy = -1; t_rise = -1; t_fall = -1; t_ack = -1; n_ack = 0;
    tick_before_rise = 1'b0; busy_hole = 1'b0;
    start = cyc;
    req = 1'b1;
    for (int i = 0; i < 200 && t_ack < 0; i++) begin
      p_tick   = slow_tick;
      p_preset = preset;
      step();
      req = 1'b0;
      if (busy && t_busy < 0) t_busy = cyc - start;
      if (t_busy >= 0 && !busy && t_ack < 0) busy_hole = 1'b1;
      if (preset && !p_preset) begin
        t_rise = cyc - start;
        tick_before_rise = p_tick;
      end
      if (!preset && p_preset) t_fall = cyc - start;
      if (ack) begin
        n_ack++;
        t_ack = cyc - start;
      end
    end
    step();
    busy_after = busy;
    if (ack) n_ack++;
  endtask

  task automatic test_reset();
    logic exp;
    reset = 1'b1; req = 1'b0; div_ratio = 2'd3; preset_len = '0; settle_len = '0;
    step();
    step();
    vectors++;
    if ({slow_tick, slow_clk, preset, busy, ack} !== 5'b00000) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %b expected 00000", {slow_tick, slow_clk, preset, busy, ack});
    end
    reset = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      step();
      exp = (n % 4 == 1);
      vectors++;
      if (slow_tick !== exp) begin
        miscompares++;
        $display("[TB] FAIL reset_tick cycle %0d: got %b expected %b", n, slow_tick, exp);
      end
      vectors++;
      if (slow_clk !== exp) begin
        miscompares++;
        $display("[TB] FAIL reset_slow_clk cycle %0d: got %b expected %b", n, slow_clk, exp);
      end
      vectors++;
      if ({preset, busy, ack} !== 3'b000) begin
        miscompares++;
        $display("[TB] FAIL reset_idle cycle %0d: got %b expected 000", n, {preset, busy, ack});
      end
    end
  endtask

  task automatic test_basic();
    int t_busy, t_rise, t_fall, t_ack, n_ack;
    logic tbr, hole, b_after;
    preset_len = 4'd2; settle_len = 4'd1;
    run_seq(t_busy, t_rise, t_fall, t_ack, n_ack, tbr, hole, b_after);
    vectors++;
    if (t_busy !== 1) begin miscompares++; $display("[TB] FAIL basic_req_to_busy: got %0d expected 1", t_busy); end
    vectors++;
    if (t_ack < 0) begin miscompares++; $display("[TB] FAIL basic_ack_timeout: got %0d expected >=0", t_ack); end
    vectors++;
    if (t_fall - t_rise !== 8) begin miscompares++; $display("[TB] FAIL basic_preset_width: got %0d expected 8", t_fall - t_rise); end
    vectors++;
    if (tbr !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_rise_after_tick: got %b expected 1", tbr); end
    vectors++;
    if (t_rise - t_busy < 1 || t_rise - t_busy > 4) begin
      miscompares++; $display("[TB] FAIL basic_align_len: got %0d expected 1..4", t_rise - t_busy);
    end
    vectors++;
    if (t_ack - t_fall !== 5) begin miscompares++; $display("[TB] FAIL basic_settle_delay: got %0d expected 5", t_ack - t_fall); end
    vectors++;
    if (n_ack !== 1) begin miscompares++; $display("[TB] FAIL basic_ack_count: got %0d expected 1", n_ack); end
    vectors++;
    if (hole !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_busy_cover: got %b expected 0", hole); end
    vectors++;
    if (b_after !== 1'b0) begin miscompares++; $display("[TB] FAIL basic_busy_after_ack: got %b expected 0", b_after); end
  endtask

  task automatic test_zero_len();
    int t_busy, t_rise, t_fall, t_ack, n_ack;
    logic tbr, hole, b_after;
    div_ratio = 2'd1;
    repeat (6) step();
    preset_len = 4'd0; settle_len = 4'd0;
    run_seq(t_busy, t_rise, t_fall, t_ack, n_ack, tbr, hole, b_after);
    vectors++;
    if (t_fall - t_rise !== 2) begin miscompares++; $display("[TB] FAIL zero_preset_width: got %0d expected 2", t_fall - t_rise); end
    vectors++;
    if (t_ack - t_fall !== 1) begin miscompares++; $display("[TB] FAIL zero_settle_delay: got %0d expected 1", t_ack - t_fall); end
    vectors++;
    if (n_ack !== 1) begin miscompares++; $display("[TB] FAIL zero_ack_count: got %0d expected 1", n_ack); end
    vectors++;
    if (tbr !== 1'b1) begin miscompares++; $display("[TB] FAIL zero_rise_after_tick: got %b expected 1", tbr); end
    vectors++;
    if (b_after !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_busy_after_ack: got %b expected 0", b_after); end
  endtask

  task automatic test_back_to_back();
    int   acks[$];
    int   widths[$];
    int   rise;
    logic p_preset;
    int   waited;
    div_ratio = 2'd0;
    repeat (4) step();
    preset_len = 4'd3; settle_len = 4'd0;
    req = 1'b1;
    rise = -1;
    for (int i = 0; i < 60; i++) begin
      p_preset = preset;
      step();
      if (preset && !p_preset) rise = cyc;
      if (!preset && p_preset) widths.push_back(cyc - rise);
      if (ack) acks.push_back(cyc);
    end
    req = 1'b0;
    waited = 0;
    while (busy && waited < 20) begin
      step();
      waited++;
    end
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_drain: got %b expected 0", busy); end
    vectors++;
    if (acks.size() < 5) begin miscompares++; $display("[TB] FAIL b2b_ack_count: got %0d expected >=5", acks.size()); end
    for (int i = 1; i < acks.size(); i++) begin
      vectors++;
      if (acks[i] - acks[i-1] !== 7) begin
        miscompares++; $display("[TB] FAIL b2b_ack_spacing %0d: got %0d expected 7", i, acks[i] - acks[i-1]);
      end
    end
    vectors++;
    if (widths.size() < 5) begin miscompares++; $display("[TB] FAIL b2b_width_count: got %0d expected >=5", widths.size()); end
    foreach (widths[i]) begin
      vectors++;
      if (widths[i] !== 3) begin
        miscompares++; $display("[TB] FAIL b2b_preset_width %0d: got %0d expected 3", i, widths[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    int   t_busy, t_rise, t_fall, t_ack, n_ack;
    logic tbr, hole, b_after;
    int   waited;
    int   stray_acks;
    logic exp;
    div_ratio = 2'd3;
    repeat (8) step();
    preset_len = 4'd4; settle_len = 4'd0;
    req = 1'b1;
    step();
    req = 1'b0;
    waited = 0;
    while (!preset && waited < 20) begin
      step();
      waited++;
    end
    vectors++;
    if (preset !== 1'b1) begin miscompares++; $display("[TB] FAIL midrst_preset_seen: got %b expected 1", preset); end
    step();
    step();
    reset = 1'b1;
    step();
    vectors++;
    if ({preset, busy, ack, slow_tick} !== 4'b0000) begin
      miscompares++; $display("[TB] FAIL midrst_abort: got %b expected 0000", {preset, busy, ack, slow_tick});
    end
    reset = 1'b0;
    stray_acks = 0;
    for (int n = 1; n <= 8; n++) begin
      step();
      exp = (n % 4 == 1);
      if (ack) stray_acks++;
      vectors++;
      if (slow_tick !== exp) begin
        miscompares++; $display("[TB] FAIL midrst_tick cycle %0d: got %b expected %b", n, slow_tick, exp);
      end
      vectors++;
      if ({preset, busy} !== 2'b00) begin
        miscompares++; $display("[TB] FAIL midrst_idle cycle %0d: got %b expected 00", n, {preset, busy});
      end
    end
    vectors++;
    if (stray_acks !== 0) begin miscompares++; $display("[TB] FAIL midrst_no_ack: got %0d expected 0", stray_acks); end
    preset_len = 4'd1; settle_len = 4'd2;
    run_seq(t_busy, t_rise, t_fall, t_ack, n_ack, tbr, hole, b_after);
    vectors++;
    if (t_fall - t_rise !== 4) begin miscompares++; $display("[TB] FAIL midrst_rerun_width: got %0d expected 4", t_fall - t_rise); end
    vectors++;
    if (t_ack - t_fall !== 9) begin miscompares++; $display("[TB] FAIL midrst_rerun_settle: got %0d expected 9", t_ack - t_fall); end
    vectors++;
    if (n_ack !== 1) begin miscompares++; $display("[TB] FAIL midrst_rerun_ack_count: got %0d expected 1", n_ack); end
  endtask

  task automatic test_ratio_change();
    int   t_busy, t_rise, t_fall, t_ack, n_ack;
    logic tbr, hole, b_after;
    int   waited;
    logic exp;
    div_ratio = 2'd3;
    repeat (8) step();
    waited = 0;
    step();
    while (!slow_tick && waited < 10) begin
      step();
      waited++;
    end
    vectors++;
    if (slow_tick !== 1'b1) begin miscompares++; $display("[TB] FAIL ratio_find_tick: got %b expected 1", slow_tick); end
    div_ratio = 2'd1;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp = (k == 4 || k == 6 || k == 8);
      vectors++;
      if (slow_tick !== exp) begin
        miscompares++; $display("[TB] FAIL ratio_tick offset %0d: got %b expected %b", k, slow_tick, exp);
      end
    end
    preset_len = 4'd2; settle_len = 4'd0;
    run_seq(t_busy, t_rise, t_fall, t_ack, n_ack, tbr, hole, b_after);
    vectors++;
    if (t_fall - t_rise !== 4) begin miscompares++; $display("[TB] FAIL ratio_preset_width: got %0d expected 4", t_fall - t_rise); end
    vectors++;
    if (t_ack - t_fall !== 1) begin miscompares++; $display("[TB] FAIL ratio_settle_delay: got %0d expected 1", t_ack - t_fall); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_back_to_back();
    test_mid_reset();
    test_ratio_change();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/preset_sequencer.md
# preset_sequencer

Controller that sequences the asynchronous preset of slow-domain registers. It derives a programmable divided tick and a registered slow clock from `clock`. On request, it asserts a glitch-free `preset` for a programmed number of slow periods, waits a programmed settle time, then acknowledges. It sits between the top-level test/control logic and any submodule whose registers use `preset` as an asynchronous reset and `slow_clk` as their clock.

## Interface
- `DIV_W`, default 2: divider counter width; slow period is `div_ratio`+1 clocks.
- `CNT_W`, default 4: width of the preset and settle length counters.

- `clock`, in, 1: the single clock; every register in this block is clocked on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `div_ratio`, in, `DIV_W`: slow period minus one; sampled only at divider wrap.
- `preset_len`, in, `CNT_W`: preset width in slow periods; 0 is treated as 1; sampled on the cycle the sequence starts.
- `settle_len`, in, `CNT_W`: slow periods between `preset` fall and `ack`; 0 is legal; sampled when `preset` falls.
- `req`, in, 1: start request; sampled only in IDLE.
- `slow_tick`, out, 1: one-cycle pulse, once per slow period.
- `slow_clk`, out, 1: registered copy of the divider-zero compare (same waveform as `slow_tick`); drives slow-domain clocks.
- `preset`, out, 1: registered preset to downstream asynchronous resets.
- `busy`, out, 1: high in every state except IDLE.
- `ack`, out, 1: one-cycle pulse at sequence completion.

## Operation
- Divider: `div_q` counts 0..`div_ratio_r` and wraps to 0. `div_ratio_r` reloads from `div_ratio` on wrap and at reset. A ratio change never truncates the current period.
- `slow_tick` and `slow_clk` are both registered as (`div_q`==0). With `div_ratio`=0, `slow_tick` is constantly 1 after the first cycle.
- FSM states: IDLE, ALIGN, ASSERT, SETTLE, DONE.
  - IDLE: on `req`=1, go to ALIGN. Capture `len_r` = max(`preset_len`,1)-1.
  - ALIGN: on `slow_tick`, set `preset`<=1, `cnt`<=`len_r`, go to ASSERT. Aligning to the tick keeps `preset` edges a fixed offset from `slow_clk`.
  - ASSERT: on each `slow_tick`, if `cnt`==0 then `preset`<=0, `cnt`<=`settle_len`, go to SETTLE; otherwise `cnt`--.
  - SETTLE: if `cnt`==0, go to DONE without waiting for a tick. Otherwise decrement on each `slow_tick`.
  - DONE: `ack`=1 for this one cycle, then go to IDLE.
- `req` is ignored outside IDLE; there is no queueing. If `req` is still high in the cycle after DONE, a new sequence starts.
- `preset` comes directly from a flop, so it never glitches. It is high only in ASSERT.
- Counter arithmetic is `CNT_W`-bit unsigned. A decrement never occurs at 0, so the counter never wraps.

## Timing
- Reset values: `div_q`=0, `slow_tick`=0, `slow_clk`=0, `preset`=0, `ack`=0, `busy`=0, FSM in IDLE.
- `slow_tick` first rises in the first cycle after `reset` is sampled low, then repeats every `div_ratio_r`+1 cycles.
- `req` to `busy`: 1 cycle.
- ALIGN duration: 0 to `div_ratio_r` cycles plus 1.
- `preset` high duration: exactly max(`preset_len`,1)×(`div_ratio_r`+1) clocks, provided `div_ratio` is stable.
- `preset` fall to `ack`: `settle_len`×(`div_ratio_r`+1) clocks plus 0 to 1 cycle of alignment; for `settle_len`=0, `ack` follows `preset` fall by 1 cycle.
- Reset mid-operation: at the reset edge, `preset`, `ack` and `busy` go to 0 and the FSM goes to IDLE. No `ack` is issued for the aborted sequence.
- `req` arriving on the same cycle as `slow_tick` in IDLE: go to ALIGN and wait for the next tick. A tick is never consumed from IDLE.

## Structure
- Package `preset_sequencer_pkg`: FSM state enum and default widths `DIV_W`/`CNT_W`.
- Submodule `tick_divider`: contains `div_q`, `div_ratio_r` and the registered `slow_tick`/`slow_clk`. It is instantiated once.
- The FSM and counters live in `preset_sequencer` itself.

## Test plan
- Reset check, `div_ratio`=3: `slow_tick` pulses in cycles 1, 5, 9…; `preset`, `ack` and `busy` stay 0 until `req`.
- Basic sequence, `div_ratio`=3, `preset_len`=2, `settle_len`=1, one-cycle `req`: `preset` high for exactly 8 clocks, rising on the cycle after a `slow_tick`; one `ack` pulse about 4–5 clocks after `preset` falls; `busy` covers the whole sequence.
- Zero lengths, `preset_len`=0, `settle_len`=0, `div_ratio`=1: `preset` high 2 clocks; `ack` 1 cycle after `preset` falls.
- `req` held high continuously, `div_ratio`=0, `preset_len`=3, `settle_len`=0: back-to-back sequences; `ack` pulses spaced by a constant period; `preset` high 3 clocks each time.
- Mid-operation reset: assert `reset` for 1 cycle while in ASSERT; `preset`=0 on the next edge, no `ack`, `div_q` restarts; a new `req` completes normally.
- Ratio change: change `div_ratio` 3→1 mid-period; the current period completes at 4 clocks and following periods are 2 clocks; `preset` width follows the new ratio only when the change happens before ALIGN.
